// File: rtl/up_sample_nn_line_buffer.sv
// ---------------------------------------------------------------------------
// up_sample_nn_line_buffer
//
// Streaming nearest-neighbour up-sampler. Input rows are written into one of
// two line banks (ping-pong). A full bank is replayed FACTOR times
// horizontally (ph) and FACTOR times vertically (rep) before it is released
// back to the write side. Counters produce the source column, so no divider
// is needed.
//
// Parameters:
//   DATA_W  pixel width in bits
//   IMG_W   input row length in pixels (>= 2)
//   IMG_H   input rows per frame (>= 1)
//   FACTOR  integer up-sample factor (1..8)
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous clear of control state (line storage is kept)
//   in_valid   input pixel valid
//   in_ready   write bank is empty and can take a pixel
//   in_data    input pixel, raster order
//   out_valid  read bank is full, out_data is meaningful
//   out_ready  downstream accepts the output pixel
//   out_data   up-sampled pixel (0 while out_valid is low)
//   out_last   final pixel of the output frame
//
// Optional feature, macro UP_SAMPLE_ROW_MARKERS_EN:
//   out_sol    first pixel of an output row
//   out_eol    last pixel of an output row
// ---------------------------------------------------------------------------
module up_sample_nn_line_buffer #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int FACTOR = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
`ifdef UP_SAMPLE_ROW_MARKERS_EN
  ,
  output logic              out_sol,
  output logic              out_eol
`endif
);

  localparam int PH_W = (FACTOR > 1) ? $clog2(FACTOR) : 1;
  localparam int SX_W = (IMG_W  > 1) ? $clog2(IMG_W)  : 1;
  localparam int OY_W = (IMG_H  > 1) ? $clog2(IMG_H)  : 1;

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(FACTOR - 1);
  localparam logic [SX_W-1:0] SX_LAST = SX_W'(IMG_W - 1);
  localparam logic [OY_W-1:0] OY_LAST = OY_W'(IMG_H - 1);

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_t;

  bank_state_t bank_state [2];
  bank_state_t bank_next  [2];

  logic [DATA_W-1:0] line_mem [2][IMG_W];

  logic            wb;
  logic            rb;
  logic [SX_W-1:0] wx;
  logic [OY_W-1:0] iy;
  logic [PH_W-1:0] ph;
  logic [SX_W-1:0] sx;
  logic [PH_W-1:0] rep;
  logic [OY_W-1:0] oy;

  logic wr_fire;
  logic wr_row_done;
  logic rd_fire;
  logic ph_last;
  logic sx_last;
  logic rep_last;
  logic oy_last;
  logic rd_release;

  // Handshake qualification. A flush cycle swallows both handshakes so that
  // nothing half-committed survives the clear.
  always_comb begin
    in_ready    = (bank_state[wb] == BANK_EMPTY);
    out_valid   = (bank_state[rb] == BANK_FULL);
    wr_fire     = in_valid && in_ready && !flush;
    rd_fire     = out_valid && out_ready && !flush;
    ph_last     = (ph  == PH_LAST);
    sx_last     = (sx  == SX_LAST);
    rep_last    = (rep == PH_LAST);
    oy_last     = (oy  == OY_LAST);
    wr_row_done = wr_fire && (wx == SX_LAST);
    rd_release  = rd_fire && ph_last && sx_last && rep_last;
  end

  // Bank ownership. Filling needs an EMPTY bank and releasing needs a FULL
  // one, so a fill and a release in the same cycle always hit different
  // banks and both updates apply.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_next[b] = bank_state[b];
    end
    if (wr_row_done) begin
      bank_next[wb] = BANK_FULL;
    end
    if (rd_release) begin
      bank_next[rb] = BANK_EMPTY;
    end
  end

  // Line storage carries no reset: its contents are only ever observed
  // through a bank that has been completely rewritten.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      line_mem[wb][wx] <= in_data;
    end
  end

  // Control state: bank flags, pointers and the write/replay counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_state[0] <= BANK_EMPTY;
      bank_state[1] <= BANK_EMPTY;
      wb  <= 1'b0;
      rb  <= 1'b0;
      wx  <= '0;
      iy  <= '0;
      ph  <= '0;
      sx  <= '0;
      rep <= '0;
      oy  <= '0;
    end else if (flush) begin
      bank_state[0] <= BANK_EMPTY;
      bank_state[1] <= BANK_EMPTY;
      wb  <= 1'b0;
      rb  <= 1'b0;
      wx  <= '0;
      iy  <= '0;
      ph  <= '0;
      sx  <= '0;
      rep <= '0;
      oy  <= '0;
    end else begin
      bank_state[0] <= bank_next[0];
      bank_state[1] <= bank_next[1];

      if (wr_fire) begin
        if (wr_row_done) begin
          wx <= '0;
          wb <= ~wb;
          iy <= (iy == OY_LAST) ? '0 : iy + 1'b1;
        end else begin
          wx <= wx + 1'b1;
        end
      end

      // Nested wrap: ph -> sx -> rep -> (release bank, next source row).
      if (rd_fire) begin
        if (ph_last) begin
          ph <= '0;
          if (sx_last) begin
            sx <= '0;
            if (rep_last) begin
              rep <= '0;
              rb  <= ~rb;
              oy  <= oy_last ? '0 : oy + 1'b1;
            end else begin
              rep <= rep + 1'b1;
            end
          end else begin
            sx <= sx + 1'b1;
          end
        end else begin
          ph <= ph + 1'b1;
        end
      end
    end
  end

  // Output pixel is read combinationally from the bank being replayed.
  always_comb begin
    out_data = out_valid ? line_mem[rb][sx] : '0;
    out_last = out_valid && ph_last && sx_last && rep_last && oy_last;
  end

`ifdef UP_SAMPLE_ROW_MARKERS_EN
  // Row markers follow the same qualification as out_data.
  always_comb begin
    out_sol = out_valid && (ph == '0) && (sx == '0);
    out_eol = out_valid && ph_last && sx_last;
  end
`endif

endmodule

// File: tb/tb_up_sample_nn_line_buffer.sv
// ---------------------------------------------------------------------------
// tb_up_sample_nn_line_buffer
//
// Three instances share one stimulus/observation port set selected by sel:
//   sel 0 : IMG_W=4, IMG_H=2, FACTOR=2
//   sel 1 : IMG_W=2, IMG_H=1, FACTOR=3
//   sel 2 : IMG_W=4, IMG_H=2, FACTOR=1
// Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_up_sample_nn_line_buffer;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;
  int          sel;

  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_sol;
  logic        out_eol;

  logic        a_in_ready, b_in_ready, c_in_ready;
  logic        a_out_valid, b_out_valid, c_out_valid;
  logic [15:0] a_out_data, b_out_data, c_out_data;
  logic        a_out_last, b_out_last, c_out_last;
  logic        a_out_sol, b_out_sol, c_out_sol;
  logic        a_out_eol, b_out_eol, c_out_eol;

  int checks;
  int failures;

  logic [15:0] in_vec[$];
  logic [15:0] exp_vec[$];

  logic [15:0] basic_exp [32] = '{
    1, 1, 2, 2, 3, 3, 4, 4,  1, 1, 2, 2, 3, 3, 4, 4,
    5, 5, 6, 6, 7, 7, 8, 8,  5, 5, 6, 6, 7, 7, 8, 8};

  logic [15:0] npow2_exp [18] = '{
    10, 10, 10, 20, 20, 20,
    10, 10, 10, 20, 20, 20,
    10, 10, 10, 20, 20, 20};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  up_sample_nn_line_buffer #(.DATA_W(16), .IMG_W(4), .IMG_H(2), .FACTOR(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid && sel == 0), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready && sel == 0),
    .out_data(a_out_data), .out_last(a_out_last)
`ifdef UP_SAMPLE_ROW_MARKERS_EN
    , .out_sol(a_out_sol), .out_eol(a_out_eol)
`endif
  );

  up_sample_nn_line_buffer #(.DATA_W(16), .IMG_W(2), .IMG_H(1), .FACTOR(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid && sel == 1), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready && sel == 1),
    .out_data(b_out_data), .out_last(b_out_last)
`ifdef UP_SAMPLE_ROW_MARKERS_EN
    , .out_sol(b_out_sol), .out_eol(b_out_eol)
`endif
  );

  up_sample_nn_line_buffer #(.DATA_W(16), .IMG_W(4), .IMG_H(2), .FACTOR(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid && sel == 2), .in_ready(c_in_ready), .in_data(in_data),
    .out_valid(c_out_valid), .out_ready(out_ready && sel == 2),
    .out_data(c_out_data), .out_last(c_out_last)
`ifdef UP_SAMPLE_ROW_MARKERS_EN
    , .out_sol(c_out_sol), .out_eol(c_out_eol)
`endif
  );

`ifndef UP_SAMPLE_ROW_MARKERS_EN
  assign a_out_sol = 1'b0;
  assign a_out_eol = 1'b0;
  assign b_out_sol = 1'b0;
  assign b_out_eol = 1'b0;
  assign c_out_sol = 1'b0;
  assign c_out_eol = 1'b0;
`endif

  // Route the selected instance onto the common observation signals.
  always_comb begin
    in_ready  = a_in_ready;
    out_valid = a_out_valid;
    out_data  = a_out_data;
    out_last  = a_out_last;
    out_sol   = a_out_sol;
    out_eol   = a_out_eol;
    if (sel == 1) begin
      in_ready  = b_in_ready;
      out_valid = b_out_valid;
      out_data  = b_out_data;
      out_last  = b_out_last;
      out_sol   = b_out_sol;
      out_eol   = b_out_eol;
    end else if (sel == 2) begin
      in_ready  = c_in_ready;
      out_valid = c_out_valid;
      out_data  = c_out_data;
      out_last  = c_out_last;
      out_sol   = c_out_sol;
      out_eol   = c_out_eol;
    end
  end

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    in_data   = '0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Streams in_vec in and checks every output handshake against exp_vec.
  // row_out/frame_out give the output row and frame lengths for the
  // marker and out_last expectations.
  task automatic run_frame(input bit bp, input string name,
                           input int row_out, input int frame_out);
    int got;
    got = 0;
    fork
      begin
        for (int i = 0; i < in_vec.size(); i++) begin
          int w;
          in_valid = 1'b1;
          in_data  = in_vec[i];
          w = 0;
          while (!in_ready && w < 2000) begin
            @(negedge clk);
            w++;
          end
          if (!in_ready) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s in_ready_timeout pixel=%0d", name, i);
            break;
          end
          @(negedge clk);
        end
        in_valid = 1'b0;
      end
      begin
        int cyc;
        bit holding;
        logic [15:0] held;
        cyc = 0;
        holding = 1'b0;
        held = '0;
        while (got < exp_vec.size() && cyc < 3000) begin
          out_ready = bp ? (cyc % 2 == 0) : 1'b1;
          if (holding) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== held) begin
              failures++;
              $display("[TB] FAIL %s stall_hold valid=%0b data=%0d required valid=1 data=%0d",
                       name, out_valid, out_data, held);
            end
            holding = 1'b0;
          end
          if (out_valid && out_ready) begin
            checks++;
            if (out_data !== exp_vec[got]) begin
              failures++;
              $display("[TB] FAIL %s data[%0d] got=%0d required=%0d",
                       name, got, out_data, exp_vec[got]);
            end
            checks++;
            if (out_last !== ((got % frame_out) == frame_out - 1)) begin
              failures++;
              $display("[TB] FAIL %s last[%0d] got=%0b required=%0b",
                       name, got, out_last, ((got % frame_out) == frame_out - 1));
            end
`ifdef UP_SAMPLE_ROW_MARKERS_EN
            checks++;
            if (out_sol !== ((got % row_out) == 0) ||
                out_eol !== ((got % row_out) == row_out - 1)) begin
              failures++;
              $display("[TB] FAIL %s markers[%0d] sol=%0b eol=%0b required sol=%0b eol=%0b",
                       name, got, out_sol, out_eol,
                       ((got % row_out) == 0), ((got % row_out) == row_out - 1));
            end
`endif
            got++;
          end else if (out_valid && !out_ready) begin
            holding = 1'b1;
            held = out_data;
          end
          @(negedge clk);
          cyc++;
        end
        out_ready = 1'b0;
      end
    join
    checks++;
    if (got != exp_vec.size()) begin
      failures++;
      $display("[TB] FAIL %s output_count got=%0d required=%0d", name, got, exp_vec.size());
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s idle_after_frame out_valid=%0b required=0", name, out_valid);
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'd0 || out_last !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset[%0d] in_ready=%0b out_valid=%0b out_data=%0d out_last=%0b required 1/0/0/0",
                 s, in_ready, out_valid, out_data, out_last);
      end
    end
    sel = 0;
  endtask

  task automatic test_basic(input bit bp, input string name);
    do_reset();
    sel = 0;
    in_vec.delete();
    exp_vec.delete();
    for (int i = 1; i <= 8; i++) in_vec.push_back(16'(i));
    for (int i = 0; i < 32; i++) exp_vec.push_back(basic_exp[i]);
    run_frame(bp, name, 8, 32);
  endtask

  task automatic test_non_pow2();
    do_reset();
    sel = 1;
    in_vec.delete();
    exp_vec.delete();
    in_vec.push_back(16'd10);
    in_vec.push_back(16'd20);
    for (int i = 0; i < 18; i++) exp_vec.push_back(npow2_exp[i]);
    run_frame(1'b0, "non_pow2", 6, 18);
    sel = 0;
  endtask

  task automatic test_ping_pong_stall();
    int nacc;
    int nout;
    bit release_seen;
    bit rose_checked;
    do_reset();
    sel = 0;
    nacc = 0;
    nout = 0;
    release_seen = 1'b0;
    rose_checked = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'd1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 100 && !rose_checked; cyc++) begin
      if (release_seen) begin
        checks++;
        if (in_ready !== 1'b1) begin
          failures++;
          $display("[TB] FAIL stall_release in_ready=%0b required=1", in_ready);
        end
        rose_checked = 1'b1;
      end else begin
        if (nacc >= 8) begin
          checks++;
          if (in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stall_hold accepted=%0d outputs=%0d in_ready=%0b required=0",
                     nacc, nout, in_ready);
          end
        end
        if (in_valid && in_ready) begin
          nacc++;
          in_data = in_data + 16'd1;
        end
        if (out_valid && out_ready) begin
          nout++;
          if (nout == 16) release_seen = 1'b1;
        end
        @(negedge clk);
      end
    end
    checks++;
    if (!rose_checked) begin
      failures++;
      $display("[TB] FAIL stall_timeout accepted=%0d outputs=%0d required outputs=16", nacc, nout);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    int n;
    do_reset();
    sel = 0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(i);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 100 && n < 5; cyc++) begin
      if (out_valid && out_ready) n++;
      @(negedge clk);
    end
    checks++;
    if (n != 5) begin
      failures++;
      $display("[TB] FAIL flush_prefill handshakes=%0d required=5", n);
    end
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'd99;
    @(negedge clk);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'd0 || out_last !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_state out_valid=%0b in_ready=%0b out_data=%0d out_last=%0b required 0/1/0/0",
               out_valid, in_ready, out_data, out_last);
    end
    in_vec.delete();
    exp_vec.delete();
    for (int i = 1; i <= 8; i++) in_vec.push_back(16'(i));
    for (int i = 0; i < 32; i++) exp_vec.push_back(basic_exp[i]);
    run_frame(1'b0, "flush_refill", 8, 32);
  endtask

  task automatic test_back_to_back();
    do_reset();
    sel = 0;
    in_vec.delete();
    exp_vec.delete();
    for (int i = 1; i <= 16; i++) in_vec.push_back(16'(i));
    for (int i = 0; i < 32; i++) exp_vec.push_back(basic_exp[i]);
    for (int i = 0; i < 32; i++) exp_vec.push_back(basic_exp[i] + 16'd8);
    run_frame(1'b0, "back_to_back", 8, 32);
  endtask

  task automatic test_pass_through();
    do_reset();
    sel = 2;
    in_vec.delete();
    exp_vec.delete();
    for (int i = 1; i <= 8; i++) begin
      in_vec.push_back(16'(i));
      exp_vec.push_back(16'(i));
    end
    run_frame(1'b0, "pass_through", 4, 8);
    sel = 0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    sel       = 0;
    $display("[TB] start");
    test_reset();
    test_basic(1'b0, "basic");
    test_non_pow2();
    test_basic(1'b1, "backpressure");
    test_ping_pong_stall();
    test_flush();
    test_back_to_back();
    test_pass_through();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
